// File: rtl/pqm_pkg.sv
// Shared constants, types and helpers for the page queue manager.
// Optional build macro used by the top: PQM_QUEUE_LEN_EN (per-queue page counters).
package pqm_pkg;

    localparam int PORT_NUM_DEF     = 16;
    localparam int PRIOR_NUM_DEF    = 8;
    localparam int PAGE_NUM_DEF     = 2048;
    localparam int AFULL_THRESH_DEF = 32;

    localparam int QNUM_DEF    = PORT_NUM_DEF * PRIOR_NUM_DEF;
    localparam int QID_W_DEF   = $clog2(QNUM_DEF);
    localparam int PTR_W_DEF   = $clog2(PAGE_NUM_DEF);
    localparam int PORT_W_DEF  = $clog2(PORT_NUM_DEF);
    localparam int PRIOR_W_DEF = $clog2(PRIOR_NUM_DEF);

    typedef logic [PTR_W_DEF-1:0] ptr_t;
    typedef logic [QID_W_DEF-1:0] qid_t;
    typedef logic [PTR_W_DEF:0]   cnt_t;

    // Queue id is the port number in the upper bits, priority in the lower bits.
    function automatic qid_t make_qid(input logic [PORT_W_DEF-1:0]  port,
                                      input logic [PRIOR_W_DEF-1:0] prior);
        return {port, prior};
    endfunction

endpackage

// File: rtl/pqm_free_list.sv
// Page allocator: bump pointer for never-used pages, LIFO free list threaded
// through the shared jump table, same-cycle release bypass and occupancy flags.
module pqm_free_list
    import pqm_pkg::*;
#(
    parameter int  PAGE_NUM     = PAGE_NUM_DEF,
    parameter int  AFULL_THRESH = AFULL_THRESH_DEF,
    localparam int PTR_W        = $clog2(PAGE_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc_req,
    input  logic             i_rel_vld,
    input  logic [PTR_W-1:0] i_rel_ptr,
    output logic             o_alloc_gnt,
    output logic [PTR_W-1:0] o_alloc_ptr,
    output logic [PTR_W:0]   o_free_cnt,
    output logic             o_full,
    output logic             o_almost_full,
    output logic [PTR_W-1:0] o_jump_rd_addr,
    input  logic [PTR_W-1:0] i_jump_rd_data,
    output logic             o_jump_wr_en,
    output logic [PTR_W-1:0] o_jump_wr_addr,
    output logic [PTR_W-1:0] o_jump_wr_data
);

    localparam logic [PTR_W:0] PAGES   = (PTR_W+1)'(PAGE_NUM);
    localparam logic [PTR_W:0] THRESH  = (PTR_W+1)'(AFULL_THRESH);
    localparam logic [PTR_W:0] CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]   r_bump;
    logic [PTR_W:0]   r_free_cnt;
    logic [PTR_W-1:0] r_fl_head;
    logic             r_gnt;
    logic [PTR_W-1:0] r_gnt_ptr;

    logic [PTR_W+1:0] w_fl_sum;
    logic             w_fl_nonempty;
    logic             w_bypass;
    logic             w_take_fl;
    logic             w_take_bump;
    logic             w_rel_only;

    // Free-list length is free pages minus the never-touched pages above the bump pointer.
    assign w_fl_sum      = {1'b0, r_free_cnt} + {1'b0, r_bump};
    assign w_fl_nonempty = w_fl_sum > {1'b0, PAGES};

    assign w_bypass    = i_alloc_req & i_rel_vld;
    assign w_take_fl   = i_alloc_req & ~i_rel_vld & w_fl_nonempty;
    assign w_take_bump = i_alloc_req & ~i_rel_vld & ~w_fl_nonempty & (r_bump < PAGES);
    assign w_rel_only  = i_rel_vld & ~i_alloc_req;

    // Grant selection, free-list push/pop, bump advance and free-page accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bump     <= '0;
            r_free_cnt <= PAGES;
            r_fl_head  <= '0;
            r_gnt      <= 1'b0;
            r_gnt_ptr  <= '0;
        end else begin
            r_gnt <= w_bypass | w_take_fl | w_take_bump;
            if (w_bypass)
                r_gnt_ptr <= i_rel_ptr;
            else if (w_take_fl)
                r_gnt_ptr <= r_fl_head;
            else if (w_take_bump)
                r_gnt_ptr <= r_bump[PTR_W-1:0];

            if (w_take_fl)
                r_fl_head <= i_jump_rd_data;
            else if (w_rel_only)
                r_fl_head <= i_rel_ptr;

            if (w_take_bump)
                r_bump <= r_bump + CNT_ONE;

            if (w_rel_only)
                r_free_cnt <= r_free_cnt + CNT_ONE;
            else if (w_take_fl | w_take_bump)
                r_free_cnt <= r_free_cnt - CNT_ONE;
        end
    end

    assign o_alloc_gnt   = r_gnt;
    assign o_alloc_ptr   = r_gnt_ptr;
    assign o_free_cnt    = r_free_cnt;
    assign o_full        = (r_free_cnt == '0);
    assign o_almost_full = (r_free_cnt <= THRESH);

    // A plain release pushes onto the list: the released page links to the old head.
    assign o_jump_rd_addr = r_fl_head;
    assign o_jump_wr_en   = w_rel_only;
    assign o_jump_wr_addr = i_rel_ptr;
    assign o_jump_wr_data = r_fl_head;

endmodule

// File: rtl/page_queue_mgr.sv
// Page queue manager for one SRAM bank: free list plus per-(port, priority)
// linked-list queues sharing one jump table.
// Build macro PQM_QUEUE_LEN_EN adds the queue_len output with per-queue page counts.
module page_queue_mgr
    import pqm_pkg::*;
#(
    parameter int  PORT_NUM     = PORT_NUM_DEF,
    parameter int  PRIOR_NUM    = PRIOR_NUM_DEF,
    parameter int  PAGE_NUM     = PAGE_NUM_DEF,
    parameter int  AFULL_THRESH = AFULL_THRESH_DEF,
    localparam int QNUM         = PORT_NUM * PRIOR_NUM,
    localparam int QID_W        = $clog2(QNUM),
    localparam int PTR_W        = $clog2(PAGE_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [PTR_W-1:0] alloc_ptr,
    input  logic             rel_vld,
    input  logic [PTR_W-1:0] rel_ptr,
    input  logic             enq_vld,
    input  logic [QID_W-1:0] enq_qid,
    input  logic [PTR_W-1:0] enq_ptr,
    input  logic             deq_req,
    input  logic [QID_W-1:0] deq_qid,
    output logic             deq_vld,
    output logic [PTR_W-1:0] deq_ptr,
    output logic             deq_err,
    output logic [QNUM-1:0]  queue_empty,
    output logic [PTR_W:0]   free_cnt,
    output logic             almost_full,
    output logic             full
`ifdef PQM_QUEUE_LEN_EN
    ,
    output logic [QNUM-1:0][PTR_W:0] queue_len
`endif
);

    // Jump table: next-page link for both the free list and every queue.
    logic [PTR_W-1:0] r_jump [PAGE_NUM];

    logic [PTR_W-1:0] r_head [QNUM];
    logic [PTR_W-1:0] r_tail [QNUM];
    logic [QNUM-1:0]  r_empty;
    logic             r_deq_vld;
    logic [PTR_W-1:0] r_deq_ptr;
    logic             r_deq_err;

    logic             w_fl_wr_en;
    logic [PTR_W-1:0] w_fl_wr_addr;
    logic [PTR_W-1:0] w_fl_wr_data;
    logic [PTR_W-1:0] w_fl_rd_addr;
    logic [PTR_W-1:0] w_fl_rd_data;

    logic             w_deq_ok;
    logic             w_deq_single;
    logic [PTR_W-1:0] w_deq_head;
    logic [PTR_W-1:0] w_deq_next;
    logic             w_enq_empty;
    logic             w_enq_wr_en;
    logic [PTR_W-1:0] w_enq_wr_addr;
    logic             w_same_q;

    pqm_free_list #(
        .PAGE_NUM     (PAGE_NUM),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_free_list (
        .clk            (clk),
        .rst            (rst),
        .i_alloc_req    (alloc_req),
        .i_rel_vld      (rel_vld),
        .i_rel_ptr      (rel_ptr),
        .o_alloc_gnt    (alloc_gnt),
        .o_alloc_ptr    (alloc_ptr),
        .o_free_cnt     (free_cnt),
        .o_full         (full),
        .o_almost_full  (almost_full),
        .o_jump_rd_addr (w_fl_rd_addr),
        .i_jump_rd_data (w_fl_rd_data),
        .o_jump_wr_en   (w_fl_wr_en),
        .o_jump_wr_addr (w_fl_wr_addr),
        .o_jump_wr_data (w_fl_wr_data)
    );

    // Queue-side decode for the addressed dequeue and enqueue queues.
    assign w_deq_head    = r_head[deq_qid];
    assign w_deq_ok      = deq_req & ~r_empty[deq_qid];
    // Pages are unique, so head == tail on a non-empty queue means exactly one page.
    assign w_deq_single  = (r_head[deq_qid] == r_tail[deq_qid]);
    assign w_enq_empty   = r_empty[enq_qid];
    assign w_enq_wr_en   = enq_vld & ~w_enq_empty;
    assign w_enq_wr_addr = r_tail[enq_qid];
    assign w_same_q      = enq_vld & deq_req & (enq_qid == deq_qid);

    // Jump-table port routing: read port A serves the free-list head, read port B
    // the dequeue head; write port A takes free-list pushes, port B queue appends.
    // The two writes always target different pages, so they never collide.
    assign w_fl_rd_data = r_jump[w_fl_rd_addr];
    assign w_deq_next   = r_jump[w_deq_head];

    // Jump-table writes; contents are deliberately left uninitialised.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fl_wr_en)
                r_jump[w_fl_wr_addr] <= w_fl_wr_data;
            if (w_enq_wr_en)
                r_jump[w_enq_wr_addr] <= enq_ptr;
        end
    end

    // Head/tail/empty maintenance and registered dequeue response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < QNUM; q++) begin
                r_head[q] <= '0;
                r_tail[q] <= '0;
            end
            r_empty   <= '1;
            r_deq_vld <= 1'b0;
            r_deq_ptr <= '0;
            r_deq_err <= 1'b0;
        end else begin
            r_deq_vld <= w_deq_ok;
            r_deq_err <= deq_req & r_empty[deq_qid];
            if (w_deq_ok)
                r_deq_ptr <= w_deq_head;

            if (w_deq_ok) begin
                if (w_deq_single) begin
                    // A same-cycle append to this queue becomes the new sole page.
                    if (w_same_q)
                        r_head[deq_qid] <= enq_ptr;
                    else
                        r_empty[deq_qid] <= 1'b1;
                end else begin
                    r_head[deq_qid] <= w_deq_next;
                end
            end

            if (enq_vld) begin
                r_tail[enq_qid] <= enq_ptr;
                if (w_enq_empty) begin
                    r_head[enq_qid]  <= enq_ptr;
                    r_empty[enq_qid] <= 1'b0;
                end
            end
        end
    end

    assign deq_vld     = r_deq_vld;
    assign deq_ptr     = r_deq_ptr;
    assign deq_err     = r_deq_err;
    assign queue_empty = r_empty;

`ifdef PQM_QUEUE_LEN_EN
    localparam logic [PTR_W:0] LEN_ONE = {{PTR_W{1'b0}}, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < QNUM; gi++) begin : g_qlen
            logic [PTR_W:0] r_len;
            logic           w_inc;
            logic           w_dec;

            assign w_inc = enq_vld & (enq_qid == QID_W'(gi));
            assign w_dec = w_deq_ok & (deq_qid == QID_W'(gi));

            // Per-queue page count; a simultaneous append and pop cancel out.
            always_ff @(posedge clk) begin
                if (rst)
                    r_len <= '0;
                else if (w_inc && !w_dec)
                    r_len <= r_len + LEN_ONE;
                else if (w_dec && !w_inc)
                    r_len <= r_len - LEN_ONE;
            end

            assign queue_len[gi] = r_len;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_page_queue_mgr.sv
// Directed bench for page_queue_mgr with an expected-result scoreboard for grants
// and dequeues. Build macro PQM_QUEUE_LEN_EN enables the queue_len checks.
`timescale 1ns/1ps
module tb_page_queue_mgr;
    import pqm_pkg::*;

    localparam int PTR_W = PTR_W_DEF;
    localparam int QID_W = QID_W_DEF;
    localparam int QNUM  = QNUM_DEF;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc_req;
    logic             alloc_gnt;
    logic [PTR_W-1:0] alloc_ptr;
    logic             rel_vld;
    logic [PTR_W-1:0] rel_ptr;
    logic             enq_vld;
    logic [QID_W-1:0] enq_qid;
    logic [PTR_W-1:0] enq_ptr;
    logic             deq_req;
    logic [QID_W-1:0] deq_qid;
    logic             deq_vld;
    logic [PTR_W-1:0] deq_ptr;
    logic             deq_err;
    logic [QNUM-1:0]  queue_empty;
    logic [PTR_W:0]   free_cnt;
    logic             almost_full;
    logic             full;
`ifdef PQM_QUEUE_LEN_EN
    logic [QNUM-1:0][PTR_W:0] queue_len;
`endif

    always #5 clk = ~clk;

    page_queue_mgr dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_ptr   (alloc_ptr),
        .rel_vld     (rel_vld),
        .rel_ptr     (rel_ptr),
        .enq_vld     (enq_vld),
        .enq_qid     (enq_qid),
        .enq_ptr     (enq_ptr),
        .deq_req     (deq_req),
        .deq_qid     (deq_qid),
        .deq_vld     (deq_vld),
        .deq_ptr     (deq_ptr),
        .deq_err     (deq_err),
        .queue_empty (queue_empty),
        .free_cnt    (free_cnt),
        .almost_full (almost_full),
        .full        (full)
`ifdef PQM_QUEUE_LEN_EN
        ,
        .queue_len   (queue_len)
`endif
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    ptr_t exp_alloc_q[$];
    ptr_t exp_deq_q[$];
    logic exp_gnt;
    logic exp_dv;
    logic exp_de;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_req = 1'b0;
        rel_vld   = 1'b0;
        rel_ptr   = '0;
        enq_vld   = 1'b0;
        enq_qid   = '0;
        enq_ptr   = '0;
        deq_req   = 1'b0;
        deq_qid   = '0;
        exp_gnt   = 1'b0;
        exp_dv    = 1'b0;
        exp_de    = 1'b0;
    endtask

    task automatic req_alloc(input ptr_t exp_ptr);
        alloc_req = 1'b1;
        exp_gnt   = 1'b1;
        exp_alloc_q.push_back(exp_ptr);
    endtask

    task automatic req_deq(input qid_t q, input ptr_t exp_ptr);
        deq_req = 1'b1;
        deq_qid = q;
        exp_dv  = 1'b1;
        exp_deq_q.push_back(exp_ptr);
    endtask

    task automatic req_enq(input qid_t q, input ptr_t p);
        enq_vld = 1'b1;
        enq_qid = q;
        enq_ptr = p;
    endtask

    // One clock: outputs are sampled 1 ns after the edge, then inputs return to idle.
    task automatic tick(input string tag);
        ptr_t e;
        @(posedge clk);
        #1;
        chk({tag, "/alloc_gnt"}, 128'(alloc_gnt), 128'(exp_gnt));
        if (exp_gnt) begin
            e = exp_alloc_q.pop_front();
            chk({tag, "/alloc_ptr"}, 128'(alloc_ptr), 128'(e));
            $display("[TB] %s: grant ptr=%0d (want %0d) free_cnt=%0d", tag, alloc_ptr, e, free_cnt);
        end
        chk({tag, "/deq_vld"}, 128'(deq_vld), 128'(exp_dv));
        chk({tag, "/deq_err"}, 128'(deq_err), 128'(exp_de));
        if (exp_dv) begin
            e = exp_deq_q.pop_front();
            chk({tag, "/deq_ptr"}, 128'(deq_ptr), 128'(e));
            $display("[TB] %s: dequeue ptr=%0d (want %0d)", tag, deq_ptr, e);
        end
        if (exp_de)
            $display("[TB] %s: dequeue on empty queue, deq_err=%0b", tag, deq_err);
        clear_inputs();
    endtask

    qid_t q17;
    qid_t q4;
    qid_t q5;
    int   fc;

    initial begin
        q17 = make_qid(4'd2, 3'd1);
        q4  = make_qid(4'd0, 3'd4);
        q5  = make_qid(4'd0, 3'd5);
        clear_inputs();
        rst = 1'b1;

        // Reset state
        tick("reset");
        chk("reset/alloc_ptr", 128'(alloc_ptr), 128'(0));
        chk("reset/deq_ptr", 128'(deq_ptr), 128'(0));
        chk("reset/queue_empty", 128'(queue_empty), '1);
        chk("reset/free_cnt", 128'(free_cnt), 128'(2048));
        chk("reset/full", 128'(full), 128'(0));
        chk("reset/almost_full", 128'(almost_full), 128'(0));
        tick("reset2");
        rst = 1'b0;

        // 1: bump allocation 0,1,2
        for (int i = 0; i < 3; i++) begin
            req_alloc(ptr_t'(i));
            tick("t1_alloc");
        end
        chk("t1/free_cnt", 128'(free_cnt), 128'(2045));

        // 2: enqueue 5,9,12 to qid 17, dequeue four times
        req_enq(q17, 11'd5);  tick("t2_enq5");
        req_enq(q17, 11'd9);  tick("t2_enq9");
        req_enq(q17, 11'd12); tick("t2_enq12");
        chk("t2/empty17_filled", 128'(queue_empty[q17]), 128'(0));
`ifdef PQM_QUEUE_LEN_EN
        chk("t2/queue_len17", 128'(queue_len[q17]), 128'(3));
`endif
        req_deq(q17, 11'd5);  tick("t2_deq1");
        req_deq(q17, 11'd9);  tick("t2_deq2");
        chk("t2/empty17_mid", 128'(queue_empty[q17]), 128'(0));
        req_deq(q17, 11'd12); tick("t2_deq3");
        chk("t2/empty17_drained", 128'(queue_empty[q17]), 128'(1));
        deq_req = 1'b1;
        deq_qid = q17;
        exp_de  = 1'b1;
        tick("t2_deq4_err");
        chk("t2/free_cnt", 128'(free_cnt), 128'(2045));

        // 3: LIFO free list ahead of bump pointer
        rel_vld = 1'b1; rel_ptr = 11'd7; tick("t3_rel7");
        chk("t3/free_cnt_rel7", 128'(free_cnt), 128'(2046));
        rel_vld = 1'b1; rel_ptr = 11'd3; tick("t3_rel3");
        chk("t3/free_cnt_rel3", 128'(free_cnt), 128'(2047));
        req_alloc(11'd3); tick("t3_alloc_a");
        req_alloc(11'd7); tick("t3_alloc_b");
        chk("t3/free_cnt_back", 128'(free_cnt), 128'(2045));

        // 4: same-cycle release bypass
        rel_vld = 1'b1; rel_ptr = 11'd100;
        req_alloc(11'd100);
        tick("t4_bypass");
        chk("t4/free_cnt", 128'(free_cnt), 128'(2045));

        // 5: enqueue + dequeue on a one-page queue
        req_enq(q4, 11'd20); tick("t5_enq20");
        req_enq(q4, 11'd21);
        req_deq(q4, 11'd20);
        tick("t5_enq_deq");
        chk("t5/empty4_between", 128'(queue_empty[q4]), 128'(0));
        req_deq(q4, 11'd21); tick("t5_deq21");
        chk("t5/empty4_after", 128'(queue_empty[q4]), 128'(1));

        // 6: exhaust the bank, then reset mid-burst
        rst = 1'b1; tick("t6_reset");
        rst = 1'b0;
        chk("t6/free_cnt_reset", 128'(free_cnt), 128'(2048));
        for (int i = 0; i < 2048; i++) begin
            req_alloc(ptr_t'(i));
            tick("t6_fill");
            fc = 2047 - i;
            chk("t6/free_cnt_fill", 128'(free_cnt), 128'(fc));
            chk("t6/almost_full_fill", 128'(almost_full), 128'(fc <= 32));
        end
        chk("t6/full", 128'(full), 128'(1));
        alloc_req = 1'b1;
        tick("t6_no_grant");
        chk("t6/free_cnt_empty", 128'(free_cnt), 128'(0));
        req_enq(q5, 11'd1); tick("t6_enq");
        chk("t6/empty5_filled", 128'(queue_empty[q5]), 128'(0));
        rel_vld = 1'b1; rel_ptr = 11'd2;
        req_alloc(11'd2);
        tick("t6_bypass_full");
        alloc_req = 1'b1;
        rst = 1'b1;
        tick("t6_rst_burst");
        rst = 1'b0;
        chk("t6/free_cnt_rst", 128'(free_cnt), 128'(2048));
        chk("t6/queue_empty_rst", 128'(queue_empty), '1);
        chk("t6/full_rst", 128'(full), 128'(0));
`ifdef PQM_QUEUE_LEN_EN
        chk("t6/queue_len5_rst", 128'(queue_len[q5]), 128'(0));
`endif
        tick("t6_idle");
        req_alloc(11'd0); tick("t6_alloc_after");
        chk("t6/free_cnt_after", 128'(free_cnt), 128'(2047));

        chk("end/alloc_queue_drained", 128'(exp_alloc_q.size()), 128'(0));
        chk("end/deq_queue_drained", 128'(exp_deq_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
